// File: rtl/spi_sample_collector_pkg.sv
// spi_sample_collector_pkg: shared slave-select codes, channel states and default width
package spi_sample_collector_pkg;
  localparam int BYTE_DEF = 8;
  localparam int SS_HR = 1;
  localparam int SS_BAG = 2;
  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} ch_state_t;
endpackage

// File: rtl/spi_sample_collector_if.sv
// spi_sample_collector_if: receive strobe, byte and slave select from the SPI master
interface spi_sample_collector_if
  import spi_sample_collector_pkg::*;
#(
  parameter int DATO = 2,
  parameter int BYTE = BYTE_DEF
) ();
  logic            done;
  logic [BYTE-1:0] rx_byte;
  logic [DATO-1:0] SS;
  modport master (output done, rx_byte, SS);
  modport slave (input done, rx_byte, SS);
endinterface

// File: rtl/spi_sample_collector_avg4_channel.sv
// avg4_channel: 4-sample moving average with fill tracking and flush
module avg4_channel
  import spi_sample_collector_pkg::*;
#(
  parameter int BYTE = BYTE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_vld,
  input  logic [BYTE-1:0] in_data,
  output logic [BYTE-1:0] value,
  output logic            valid
);
  ch_state_t       state, state_nx;
  logic [1:0]      cnt, cnt_nx;
  logic [BYTE-1:0] fifo [4];
  logic [BYTE+1:0] sum, sum_nx;
  // next fill state and running sum; the oldest slot is zero until the fifo is full
  always_comb begin
    sum_nx = sum - {2'b00, fifo[3]} + {2'b00, in_data};
    state_nx = flush ? EMPTY : !in_vld ? state : state == EMPTY ? FILLING :
               (state == FILLING && cnt == 2'd3) ? FULL : state;
    cnt_nx = flush ? 2'd0 : (in_vld && state != FULL) ? cnt + 2'd1 : cnt;
  end
  // fill state register
  always_ff @(posedge clk)
    if (!rst) begin
      state <= EMPTY;
      cnt <= 2'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // sample fifo and sum, cleared on flush
  always_ff @(posedge clk)
    if (!rst || flush) begin
      fifo <= '{default: '0};
      sum <= '0;
    end else if (in_vld) begin
      fifo <= '{in_data, fifo[0], fifo[1], fifo[2]};
      sum <= sum_nx;
    end
  // publish the average only once four samples are held; flush leaves the value alone
  always_ff @(posedge clk)
    if (!rst) begin
      value <= '0;
      valid <= 1'b0;
    end else begin
      valid <= in_vld && state_nx == FULL;
      if (in_vld && state_nx == FULL) value <= sum_nx[BYTE+1:2];
    end
endmodule

// File: rtl/spi_sample_collector.sv
// spi_sample_collector: routes SPI samples to heart-rate and bag averagers, raises bag-low alarm
module spi_sample_collector
  import spi_sample_collector_pkg::*;
#(
  parameter int DATO = 2,
  parameter int BYTE = BYTE_DEF,
  parameter int HYST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_sample_collector_if.slave bus,
  input  logic                  clear,
  input  logic [BYTE-1:0]       thr_low,
  output logic [BYTE-1:0]       hr_value,
  output logic [BYTE-1:0]       bag_value,
  output logic                  hr_valid,
  output logic                  bag_valid,
  output logic                  alarm_bag,
  output logic [3:0]            err_cnt
);
  logic            s1_vld;
  logic [BYTE-1:0] s1_byte;
  logic [DATO-1:0] s1_ss;
  logic            is_hr, is_bag;
  logic [BYTE:0]   thr_rel;
  assign is_hr = bus.SS == DATO'(SS_HR);
  assign is_bag = bus.SS == DATO'(SS_BAG);
  assign thr_rel = {1'b0, thr_low} + (BYTE+1)'(HYST);
  // stage 1: capture the sample; a bag sample arriving together with clear is dropped
  always_ff @(posedge clk)
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_byte <= '0;
      s1_ss <= '0;
    end else begin
      s1_vld <= bus.done && (is_hr || (is_bag && !clear));
      if (bus.done) begin
        s1_byte <= bus.rx_byte;
        s1_ss <= bus.SS;
      end
    end
  // saturating count of strobes addressed to no known sensor
  always_ff @(posedge clk)
    if (!rst) err_cnt <= 4'd0;
    else if (bus.done && !is_hr && !is_bag && err_cnt != 4'hf) err_cnt <= err_cnt + 4'd1;
  avg4_channel #(.BYTE(BYTE)) u_hr (
    .clk     (clk),
    .rst     (rst),
    .flush   (1'b0),
    .in_vld  (s1_vld && s1_ss == DATO'(SS_HR)),
    .in_data (s1_byte),
    .value   (hr_value),
    .valid   (hr_valid)
  );
  avg4_channel #(.BYTE(BYTE)) u_bag (
    .clk     (clk),
    .rst     (rst),
    .flush   (clear),
    .in_vld  (s1_vld && s1_ss == DATO'(SS_BAG)),
    .in_data (s1_byte),
    .value   (bag_value),
    .valid   (bag_valid)
  );
  // alarm re-evaluated on each new full-window bag average; clear wins
  always_ff @(posedge clk)
    alarm_bag <= (!rst || clear) ? 1'b0 : !bag_valid ? alarm_bag :
                 bag_value < thr_low ? 1'b1 :
                 {1'b0, bag_value} >= thr_rel ? 1'b0 : alarm_bag;
endmodule

// File: tb/tb_spi_sample_collector.sv
// tb_spi_sample_collector: randomized and directed checks against a queue-based reference model
module tb_spi_sample_collector;
  localparam int HYST = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] thr_low = 8'd0;
  logic [7:0] hr_value, bag_value;
  logic       hr_valid, bag_valid, alarm_bag;
  logic [3:0] err_cnt;
  int tests = 0;
  int fails = 0;
  int q_hr[$];
  int q_bag[$];
  logic [7:0] m_hr, m_bag;
  logic       m_alarm;
  int         m_err;
  logic       p_vld;
  logic [1:0] p_ss;
  logic [7:0] p_b;
  int vld_mis, hr_pulse, bag_pulse, exp_hr_pulse, exp_bag_pulse;

  spi_sample_collector_if #(.DATO(2), .BYTE(8)) bus ();

  spi_sample_collector #(.DATO(2), .BYTE(8), .HYST(HYST)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clear     (clear),
    .thr_low   (thr_low),
    .hr_value  (hr_value),
    .bag_value (bag_value),
    .hr_valid  (hr_valid),
    .bag_valid (bag_valid),
    .alarm_bag (alarm_bag),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q_hr.delete();
    q_bag.delete();
    m_hr = 0;
    m_bag = 0;
    m_alarm = 0;
    m_err = 0;
    p_vld = 0;
    p_ss = 0;
    p_b = 0;
  endtask

  task automatic clr_counts();
    vld_mis = 0;
    hr_pulse = 0;
    bag_pulse = 0;
    exp_hr_pulse = 0;
    exp_bag_pulse = 0;
  endtask

  // one clock: drive inputs, advance the reference model, tally pulses and per-cycle disagreement
  task automatic tick(input logic d, input logic [1:0] s, input logic [7:0] b, input logic c);
    logic ehv, ebv;
    int sm;
    bus.done = d;
    bus.SS = s;
    bus.rx_byte = b;
    clear = c;
    @(posedge clk);
    #1;
    bus.done = 0;
    clear = 0;
    ehv = 0;
    ebv = 0;
    if (p_vld && p_ss == 2'd1) begin
      q_hr.push_back(p_b);
      if (q_hr.size() > 4) void'(q_hr.pop_front());
      if (q_hr.size() == 4) begin
        sm = 0;
        foreach (q_hr[i]) sm += q_hr[i];
        m_hr = 8'(sm / 4);
        ehv = 1;
      end
    end
    if (p_vld && p_ss == 2'd2 && !c) begin
      q_bag.push_back(p_b);
      if (q_bag.size() > 4) void'(q_bag.pop_front());
      if (q_bag.size() == 4) begin
        sm = 0;
        foreach (q_bag[i]) sm += q_bag[i];
        m_bag = 8'(sm / 4);
        ebv = 1;
        if (int'(m_bag) < int'(thr_low)) m_alarm = 1;
        else if (int'(m_bag) >= int'(thr_low) + HYST) m_alarm = 0;
      end
    end
    if (c) begin
      q_bag.delete();
      m_alarm = 0;
    end
    p_vld = d && (s == 2'd1 || s == 2'd2) && !(c && s == 2'd2);
    p_ss = s;
    p_b = b;
    if (d && s != 2'd1 && s != 2'd2 && m_err < 15) m_err++;
    exp_hr_pulse += int'(ehv);
    exp_bag_pulse += int'(ebv);
    hr_pulse += int'(hr_valid);
    bag_pulse += int'(bag_valid);
    if (hr_valid !== ehv || bag_valid !== ebv || hr_value !== m_hr || bag_value !== m_bag) vld_mis++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 2'd0, 8'd0, 0);
  endtask

  task automatic test_reset();
    rst = 0;
    bus.done = 0;
    bus.SS = 0;
    bus.rx_byte = 0;
    repeat (2) @(posedge clk);
    #1;
    tests += 6;
    if (hr_value !== 8'd0) begin fails++; $display("FAIL reset_hr_value: got %0d expected 0", hr_value); end
    if (bag_value !== 8'd0) begin fails++; $display("FAIL reset_bag_value: got %0d expected 0", bag_value); end
    if (hr_valid !== 1'b0) begin fails++; $display("FAIL reset_hr_valid: got %0b expected 0", hr_valid); end
    if (bag_valid !== 1'b0) begin fails++; $display("FAIL reset_bag_valid: got %0b expected 0", bag_valid); end
    if (alarm_bag !== 1'b0) begin fails++; $display("FAIL reset_alarm: got %0b expected 0", alarm_bag); end
    if (err_cnt !== 4'd0) begin fails++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    model_reset();
    rst = 1;
  endtask

  task automatic test_hr_fill();
    clr_counts();
    tick(1, 2'd1, 8'd10, 0); idle(3);
    tick(1, 2'd1, 8'd20, 0); idle(3);
    tick(1, 2'd1, 8'd30, 0); idle(3);
    tests++;
    if (hr_pulse !== 0) begin fails++; $display("FAIL hr_fill_early_pulses: got %0d expected 0", hr_pulse); end
    tick(1, 2'd1, 8'd40, 0);
    tests++;
    if (hr_valid !== 1'b0) begin fails++; $display("FAIL hr_fill_valid_1cyc: got %0b expected 0", hr_valid); end
    tick(0, 2'd0, 8'd0, 0);
    tests += 3;
    if (hr_valid !== 1'b1) begin fails++; $display("FAIL hr_fill_valid_2cyc: got %0b expected 1", hr_valid); end
    if (hr_value !== 8'd25) begin fails++; $display("FAIL hr_fill_value: got %0d expected 25", hr_value); end
    idle(2);
    if (vld_mis !== 0) begin fails++; $display("FAIL hr_fill_cycle_model: got %0d mismatched cycles expected 0", vld_mis); end
  endtask

  task automatic test_hr_overflow();
    clr_counts();
    tick(1, 2'd1, 8'd50, 0); idle(3);
    tests++;
    if (hr_value !== 8'd35) begin fails++; $display("FAIL hr_avg35: got %0d expected 35", hr_value); end
    for (int i = 0; i < 4; i++) tick(1, 2'd1, 8'd255, 0);
    idle(3);
    tests += 3;
    if (hr_value !== 8'd255) begin fails++; $display("FAIL hr_max: got %0d expected 255", hr_value); end
    if (hr_pulse !== exp_hr_pulse) begin fails++; $display("FAIL hr_b2b_pulses: got %0d expected %0d", hr_pulse, exp_hr_pulse); end
    if (vld_mis !== 0) begin fails++; $display("FAIL hr_b2b_cycle_model: got %0d mismatched cycles expected 0", vld_mis); end
  endtask

  task automatic test_alarm();
    clr_counts();
    thr_low = 8'd100;
    for (int i = 0; i < 4; i++) tick(1, 2'd2, 8'd90, 0);
    idle(3);
    tests += 2;
    if (bag_value !== 8'd90) begin fails++; $display("FAIL bag_avg90: got %0d expected 90", bag_value); end
    if (alarm_bag !== 1'b1) begin fails++; $display("FAIL alarm_set: got %0b expected 1", alarm_bag); end
    for (int i = 0; i < 4; i++) tick(1, 2'd2, 8'd102, 0);
    idle(3);
    tests += 2;
    if (bag_value !== 8'd102) begin fails++; $display("FAIL bag_avg102: got %0d expected 102", bag_value); end
    if (alarm_bag !== 1'b1) begin fails++; $display("FAIL alarm_hyst_hold: got %0b expected 1", alarm_bag); end
    for (int i = 0; i < 3; i++) tick(1, 2'd2, 8'd104, 0);
    idle(3);
    tests += 2;
    if (bag_value !== 8'd103) begin fails++; $display("FAIL bag_avg103: got %0d expected 103", bag_value); end
    if (alarm_bag !== 1'b1) begin fails++; $display("FAIL alarm_hold_103: got %0b expected 1", alarm_bag); end
    tick(1, 2'd2, 8'd104, 0);
    idle(3);
    tests += 3;
    if (bag_value !== 8'd104) begin fails++; $display("FAIL bag_avg104: got %0d expected 104", bag_value); end
    if (alarm_bag !== 1'b0) begin fails++; $display("FAIL alarm_release: got %0b expected 0", alarm_bag); end
    if (vld_mis !== 0) begin fails++; $display("FAIL alarm_cycle_model: got %0d mismatched cycles expected 0", vld_mis); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) tick(1, 2'd2, 8'd50, 0);
    idle(3);
    tests++;
    if (alarm_bag !== 1'b1) begin fails++; $display("FAIL clear_pre_alarm: got %0b expected 1", alarm_bag); end
    clr_counts();
    tick(1, 2'd2, 8'd200, 1);
    idle(3);
    tests += 2;
    if (alarm_bag !== 1'b0) begin fails++; $display("FAIL clear_alarm: got %0b expected 0", alarm_bag); end
    if (bag_value !== 8'd50) begin fails++; $display("FAIL clear_value_hold: got %0d expected 50", bag_value); end
    tick(1, 2'd2, 8'd60, 0);
    tick(1, 2'd2, 8'd70, 0);
    tick(1, 2'd2, 8'd80, 0);
    idle(3);
    tests++;
    if (bag_pulse !== 0) begin fails++; $display("FAIL clear_refill_pulses: got %0d expected 0", bag_pulse); end
    tick(1, 2'd2, 8'd90, 0);
    idle(3);
    tests++;
    if (bag_value !== 8'd75) begin fails++; $display("FAIL clear_refill_avg: got %0d expected 75", bag_value); end
    clr_counts();
    tick(1, 2'd2, 8'd250, 0);
    tick(0, 2'd0, 8'd0, 1);
    idle(3);
    tests += 2;
    if (bag_pulse !== 0) begin fails++; $display("FAIL clear_stage2_pulse: got %0d expected 0", bag_pulse); end
    if (bag_value !== 8'd75) begin fails++; $display("FAIL clear_stage2_hold: got %0d expected 75", bag_value); end
    for (int i = 0; i < 4; i++) tick(1, 2'd2, 8'd8, 0);
    idle(3);
    tests++;
    if (bag_value !== 8'd8) begin fails++; $display("FAIL clear_stage2_refill: got %0d expected 8", bag_value); end
    tick(1, 2'd1, 8'd100, 1);
    idle(3);
    tests += 2;
    if (hr_value !== 8'd216) begin fails++; $display("FAIL clear_hr_unaffected: got %0d expected 216", hr_value); end
    if (vld_mis !== 0) begin fails++; $display("FAIL clear_cycle_model: got %0d mismatched cycles expected 0", vld_mis); end
  endtask

  task automatic test_err();
    clr_counts();
    for (int i = 0; i < 3; i++) tick(1, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0, 8'($urandom), 0);
    idle(2);
    tests++;
    if (err_cnt !== 4'd3) begin fails++; $display("FAIL err_count3: got %0d expected 3", err_cnt); end
    for (int i = 0; i < 14; i++) tick(1, 2'd0, 8'($urandom), 0);
    idle(2);
    tests += 4;
    if (err_cnt !== 4'd15) begin fails++; $display("FAIL err_saturate: got %0d expected 15", err_cnt); end
    if (hr_value !== m_hr) begin fails++; $display("FAIL err_hr_hold: got %0d expected %0d", hr_value, m_hr); end
    if (bag_value !== m_bag) begin fails++; $display("FAIL err_bag_hold: got %0d expected %0d", bag_value, m_bag); end
    if (hr_pulse + bag_pulse !== 0) begin fails++; $display("FAIL err_pulses: got %0d expected 0", hr_pulse + bag_pulse); end
  endtask

  task automatic test_reset_midflight();
    tick(1, 2'd1, 8'd77, 0);
    rst = 0;
    @(posedge clk);
    #1;
    tests += 5;
    if (hr_valid !== 1'b0) begin fails++; $display("FAIL midrst_hr_valid: got %0b expected 0", hr_valid); end
    if (hr_value !== 8'd0) begin fails++; $display("FAIL midrst_hr_value: got %0d expected 0", hr_value); end
    if (bag_value !== 8'd0) begin fails++; $display("FAIL midrst_bag_value: got %0d expected 0", bag_value); end
    if (err_cnt !== 4'd0) begin fails++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt); end
    if (alarm_bag !== 1'b0) begin fails++; $display("FAIL midrst_alarm: got %0b expected 0", alarm_bag); end
    model_reset();
    rst = 1;
    clr_counts();
    idle(4);
    tests += 2;
    if (hr_pulse !== 0) begin fails++; $display("FAIL midrst_no_pulse: got %0d expected 0", hr_pulse); end
    if (vld_mis !== 0) begin fails++; $display("FAIL midrst_cycle_model: got %0d mismatched cycles expected 0", vld_mis); end
  endtask

  task automatic test_random();
    logic [1:0] s;
    thr_low = 8'($urandom_range(40, 200));
    clr_counts();
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0) :
          (($urandom_range(0, 1) != 0) ? 2'd2 : 2'd1);
      tick($urandom_range(0, 3) != 0, s, 8'($urandom), $urandom_range(0, 39) == 0);
    end
    idle(4);
    tests += 5;
    if (vld_mis !== 0) begin fails++; $display("FAIL rand_cycle_model: got %0d mismatched cycles expected 0", vld_mis); end
    if (hr_pulse !== exp_hr_pulse) begin fails++; $display("FAIL rand_hr_pulses: got %0d expected %0d", hr_pulse, exp_hr_pulse); end
    if (bag_pulse !== exp_bag_pulse) begin fails++; $display("FAIL rand_bag_pulses: got %0d expected %0d", bag_pulse, exp_bag_pulse); end
    if (err_cnt !== 4'(m_err)) begin fails++; $display("FAIL rand_err_cnt: got %0d expected %0d", err_cnt, m_err); end
    if (alarm_bag !== m_alarm) begin fails++; $display("FAIL rand_alarm: got %0b expected %0b", alarm_bag, m_alarm); end
  endtask

  initial begin
    test_reset();
    test_hr_fill();
    test_hr_overflow();
    test_alarm();
    test_clear();
    test_err();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_sample_collector.md
SPI_SAMPLE_COLLECTOR -- requirements
Module: spi_sample_collector

Interface
REQ-001 SHALL have parameter DATO, default 2: slave-select width.
REQ-002 SHALL have parameter BYTE, default 8: received sample width.
REQ-003 SHALL have parameter HYST, default 4: alarm release hysteresis, in LSB.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 done  input  1  one-cycle pulse from the SPI master; rx_byte is valid in that cycle.
REQ-007 rx_byte  input  BYTE  byte received from the sensor.
REQ-008 SS  input  DATO  slave select from the transmit FSM: 1 = heart-rate sensor (ch1), 2 = bag-weight sensor (ch2).
REQ-009 clear  input  1  bag-change pulse; flushes ch2.
REQ-010 thr_low  input  BYTE  bag-low threshold, static while ch2 is FULL.
REQ-011 hr_value  output  BYTE  ch1 4-sample average.
REQ-012 bag_value  output  BYTE  ch2 4-sample average.
REQ-013 hr_valid  output  1  one-cycle pulse when hr_value updates.
REQ-014 bag_valid  output  1  one-cycle pulse when bag_value updates.
REQ-015 alarm_bag  output  1  bag below threshold, with hysteresis.
REQ-016 err_cnt  output  4  saturating count of done pulses with SS not 1 and not 2.

Function
REQ-017 Stage 1: when done=1, register rx_byte and SS in the same edge; with done=0, the stage is idle.
REQ-018 Stage 2: update the selected channel one cycle after stage 1.
- Valid pulse and new value appear 2 cycles after the done cycle.
REQ-019 Each channel has a 4-entry sample FIFO (shift register) and a running sum of BYTE+2 bits.
- Update: sum_next = sum - oldest + new; no overflow by construction.
REQ-020 Channel average = sum[BYTE+1:2], truncating.
REQ-021 Each channel runs a state machine:
- EMPTY -> FILLING on the first sample.
- FILLING counts 1..3 samples; the 4th sample moves it to FULL.
- FULL stays in FULL.
REQ-022 Valid pulses and value updates occur only in FULL, including the transition cycle into FULL; while EMPTY/FILLING, outputs hold their previous value.
REQ-023 A done with SS=0 or SS=3 stores no sample and increments err_cnt, saturating at 15.
REQ-024 alarm_bag sets when ch2 is FULL and bag average < thr_low.
REQ-025 alarm_bag clears when bag average >= thr_low + HYST (compared at BYTE+1 bits), or on clear.
REQ-026 clear, in any state, puts ch2 to EMPTY next cycle: zero FIFO, sum and fill count; deassert alarm_bag; bag_value holds.
REQ-027 If clear coincides with a ch2 sample in stage 1 or stage 2, clear wins and the sample is discarded.
REQ-028 ch1 is unaffected by clear.
REQ-029 done pulses on consecutive cycles are all accepted; there is no backpressure.

Reset
REQ-030 With rst=0 at a clock edge, all outputs SHALL be 0, both channels EMPTY, FIFOs, sums and pipeline registers zero.
REQ-031 Reset asserted mid-pipeline discards in-flight samples; no valid pulse follows release.

Structure
REQ-032 A shared package holds:
- SS codes SS_HR=1, SS_BAG=2;
- channel state encoding EMPTY/FILLING/FULL;
- the default BYTE width.
REQ-033 Sub-module avg4_channel (FIFO, sum, fill FSM, flush input) is instantiated twice; alarm, error count and stage 1 stay in the top.

Verification
REQ-034 Scenario: SS=1, rx_byte 10,20,30,40 on four done pulses -> first three give no hr_valid; 4th gives hr_value=25 with hr_valid 2 cycles after done.
REQ-035 Scenario: continue ch1 with 50 -> hr_value=35 (sum 140); then 255 x4 -> hr_value=255 with no overflow.
REQ-036 Scenario: thr_low=100, ch2 fills with 90 x4 -> alarm_bag=1.
- Then 102 x4 -> alarm stays 1 (102 < 104).
- Then 104 x4 -> alarm clears when the average reaches 104.
REQ-037 Scenario: clear in the same cycle as a ch2 done -> sample dropped, ch2 EMPTY, alarm_bag=0; the next 3 ch2 samples produce no bag_valid.
REQ-038 Scenario: done with SS=0 x17 -> err_cnt=15; hr/bag outputs unchanged.
REQ-039 Scenario: rst=0 one cycle after a ch1 done in FULL -> no hr_valid; all outputs 0 after the edge.
